// File: rtl/pwm_audio_mc.sv
// ---------------------------------------------------------------------------
// pwm_audio_mc
//
// Multi-channel audio PWM output stage with double-buffered sample intake.
// One frame (one sample per channel) is accepted per PWM period through a
// valid/ready handshake. Frames are parked in a pending buffer and moved
// into the active buffer atomically at the period boundary, so every
// channel changes duty on the same clock.
//
// PWM period P = 2^WIDTH - 1 clocks. The counter runs 0..P-1, and the
// boundary cycle is the one with count == P-1.
//
// Optional feature macro: PWM_AUDIO_SD_EN
//   When defined, the mode input selects first-order sigma-delta
//   modulation (mode = 1) instead of PWM (mode = 0). The mode is sampled
//   at each boundary. When undefined, mode is ignored and only PWM exists.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   sample_data   CHANNELS*WIDTH, channel c at [c*WIDTH +: WIDTH], unsigned
//   sample_valid  upstream presents a frame on sample_data
//   sample_ready  pending buffer can take a frame
//   mode          0 = PWM, 1 = sigma-delta (PWM_AUDIO_SD_EN builds only)
//   pwm           CHANNELS registered audio outputs
//   frame_start   one-cycle pulse, first cycle of each new period
//   underrun      one-cycle pulse with frame_start when no frame arrived
// ---------------------------------------------------------------------------
module pwm_audio_mc #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      frame_start,
    output logic                      underrun
);

    // Last count value of a period: 2^WIDTH - 2 (all ones except the LSB).
    localparam logic [WIDTH-1:0] COUNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0]    count;
    logic [WIDTH-1:0]    pending [CHANNELS];
    logic [WIDTH-1:0]    active  [CHANNELS];
    logic                pending_full;
    logic                boundary;
    logic                handshake;
    logic [CHANNELS-1:0] pwm_next;

    assign boundary     = (count == COUNT_LAST);
    assign sample_ready = !pending_full && !rst;
    assign handshake    = sample_valid && sample_ready;

    // Period counter, buffer hand-over and status pulses.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, regardless of statement order.
        if (rst) begin
            count        <= '0;
            pending_full <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            pwm          <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                active[c] <= '0;
            end
        end else begin
            count       <= boundary ? '0 : count + 1'b1;
            frame_start <= boundary;
            // A boundary with neither a parked frame nor a live handshake
            // leaves the previous frame playing and flags it upstream.
            underrun    <= boundary && !pending_full && !handshake;
            pwm         <= pwm_next;

            if (boundary) begin
                // sample_ready is low whenever pending is full, so the two
                // branches below can never both want to load active.
                if (pending_full) begin
                    pending_full <= 1'b0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        active[c] <= pending[c];
                    end
                end else if (handshake) begin
                    // Frame arriving exactly on the boundary bypasses pending.
                    for (int c = 0; c < CHANNELS; c++) begin
                        active[c] <= sample_data[c*WIDTH +: WIDTH];
                    end
                end
            end else if (handshake) begin
                pending_full <= 1'b1;
            end
        end
    end

    // Pending sample storage. Its contents are only ever read when
    // pending_full is set, so the data itself needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: data buffers guarded by a valid flag are left unreset; only
        // the flag is reset, which keeps reset fan-out off the datapath.
        if (handshake && !boundary) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pending[c] <= sample_data[c*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PWM_AUDIO_SD_EN
    // Sigma-delta path. acc holds the WIDTH-bit residue; the carry out of
    // each addition (bit WIDTH of the sum) is the output pulse and is held
    // in the pwm register rather than in acc.
    logic             mode_q;
    logic [WIDTH-1:0] acc     [CHANNELS];
    logic [WIDTH:0]   acc_sum [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            acc_sum[c] = {1'b0, acc[c]} + {1'b0, active[c]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            if (boundary) begin
                mode_q <= mode;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                // Restart the modulator cleanly whenever the mode flips.
                if (boundary && (mode != mode_q)) begin
                    acc[c] <= '0;
                end else if (mode_q) begin
                    acc[c] <= acc_sum[c][WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the block
        // leaves pwm_next unassigned, which would infer a latch.
        pwm_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pwm_next[c] = mode_q ? acc_sum[c][WIDTH] : (count < active[c]);
        end
    end
`else
    // PWM-only build: mode has no effect.
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        pwm_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pwm_next[c] = (count < active[c]);
        end
    end
`endif

endmodule

// File: tb/tb_pwm_audio_mc.sv
// ---------------------------------------------------------------------------
// tb_pwm_audio_mc
//
// Self-checking bench for pwm_audio_mc with WIDTH = 4 (P = 15), CHANNELS = 2.
// Tests push the expected per-period result (underrun flag and duty of each
// channel) into a queue when they drive a frame, or when they deliberately
// skip one. A negedge monitor pops an entry at every frame_start, checks
// the underrun flag there, and checks the duty once the period has played.
// Build with +define+PWM_AUDIO_SD_EN to exercise the sigma-delta path.
// ---------------------------------------------------------------------------
module tb_pwm_audio_mc;

    localparam int W  = 4;
    localparam int CH = 2;
    localparam int P  = (1 << W) - 1;

    typedef struct {
        bit ur;
        int d0;
        int d1;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] sample_data;
    logic            sample_valid;
    logic            sample_ready;
    logic            mode;
    logic [CH-1:0]   pwm;
    logic            frame_start;
    logic            underrun;

    int   total = 0;
    int   bad   = 0;
    int   phase = 0;   // expected DUT count
    int   cyc   = 0;   // cycles since reset release
    bit   mon_en = 1'b0;
    bit   have_cur = 1'b0;
    exp_t cur;
    exp_t exp_q[$];
    int   last0 = 0;
    int   last1 = 0;
    int   mon_hi0 = 0;
    int   mon_hi1 = 0;
    bit   fs_exp;

    pwm_audio_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mode         (mode),
        .pwm          (pwm),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Independent timeline of the expected period counter.
    always @(posedge clk) begin
        if (rst) begin
            phase <= 0;
            cyc   <= 0;
        end else begin
            phase <= (phase == P - 1) ? 0 : phase + 1;
            cyc   <= cyc + 1;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!mon_en) begin
            have_cur = 1'b0;
            mon_hi0  = 0;
            mon_hi1  = 0;
        end else begin
            fs_exp = (phase == 0) && (cyc >= P);
            total++;
            if (frame_start !== fs_exp) begin
                bad++;
                $display("FAIL frame_start cycle %0d: got %b want %b", cyc, frame_start, fs_exp);
            end
            mon_hi0 += int'(pwm[0]);
            mon_hi1 += int'(pwm[1]);
            if (!fs_exp) begin
                total++;
                if (underrun !== 1'b0) begin
                    bad++;
                    $display("FAIL underrun_idle cycle %0d: got %b want 0", cyc, underrun);
                end
            end else begin
                if (have_cur) begin
                    total += 2;
                    if (mon_hi0 != cur.d0) begin
                        bad++;
                        $display("FAIL duty_ch0 cycle %0d: got %0d want %0d", cyc, mon_hi0, cur.d0);
                    end
                    if (mon_hi1 != cur.d1) begin
                        bad++;
                        $display("FAIL duty_ch1 cycle %0d: got %0d want %0d", cyc, mon_hi1, cur.d1);
                    end
                end
                mon_hi0 = 0;
                mon_hi1 = 0;
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    total++;
                    if (underrun !== cur.ur) begin
                        bad++;
                        $display("FAIL underrun_frame cycle %0d: got %b want %b", cyc, underrun, cur.ur);
                    end
                end else begin
                    have_cur = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic do_reset;
        mon_en       = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        last0 = 0;
        last1 = 0;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        @(negedge clk);
        while (cyc != n && guard < 6 * P) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: reached cycle %0d want %0d", cyc, n);
        end
    endtask

    // Hold a frame on the bus until accepted; returns the acceptance cycle.
    task automatic send(input int d0, input int d1, output int acc_cyc);
        int guard = 0;
        sample_data  = {W'(d1), W'(d0)};
        sample_valid = 1'b1;
        acc_cyc      = -1;
        while (acc_cyc < 0 && guard < 3 * P) begin
            if (sample_ready === 1'b1) acc_cyc = cyc;
            @(negedge clk);
            guard++;
        end
        sample_valid = 1'b0;
        if (acc_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no ready want ready within %0d cycles", 3 * P);
        end
    endtask

    task automatic expect_period(input bit ur, input int d0, input int d1);
        exp_t e;
        e.ur = ur;
        e.d0 = d0;
        e.d1 = d1;
        exp_q.push_back(e);
        last0 = d0;
        last1 = d1;
    endtask

    task automatic expect_frame(input int d0, input int d1);
        expect_period(1'b0, d0, d1);
    endtask

    task automatic expect_repeat;
        expect_period(1'b1, last0, last1);
    endtask

    task automatic drain;
        int guard = 0;
        while ((exp_q.size() != 0 || have_cur) && guard < 20 * P) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || have_cur) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        mon_en = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset;
        int a;
        int hi;
        do_reset;
        wait_cyc(3);
        send(9, 9, a);
        wait_cyc(20);
        send(2, 2, a);                 // parked in pending
        total++;
        if (pwm !== 2'b11) begin
            bad++;
            $display("FAIL reset_pre_pwm: got %b want 11", pwm);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total += 2;
            if (pwm !== 2'b00) begin
                bad++;
                $display("FAIL reset_pwm: got %b want 00", pwm);
            end
            if (sample_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready: got %b want 0", sample_ready);
            end
        end
        rst = 1'b0;
        #1;
        total += 3;
        if (sample_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b want 1", sample_ready);
        end
        if (underrun !== 1'b0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL release_pulses: got ur=%b fs=%b want 0 0", underrun, frame_start);
        end
        if (pwm !== 2'b00) begin
            bad++;
            $display("FAIL release_pwm: got %b want 00", pwm);
        end
        // Active and pending were discarded: output stays low.
        hi = 0;
        repeat (2 * P) begin
            @(negedge clk);
            hi += $countones(pwm);
        end
        total++;
        if (hi != 0) begin
            bad++;
            $display("FAIL reset_discard: got %0d high cycles want 0", hi);
        end
    endtask

    task automatic test_duty;
        int a;
        do_reset;
        mon_en = 1'b1;
        wait_cyc(3);
        expect_frame(5, 15);
        expect_repeat;
        expect_repeat;
        send(5, 15, a);
        wait_cyc(2 * P + 7);           // compare at count 6: ch0 low, ch1 high
        total++;
        if (pwm !== 2'b10) begin
            bad++;
            $display("FAIL duty_mid: got %b want 10", pwm);
        end
        wait_cyc(3 * P + 5);
        expect_frame(0, 15);
        expect_repeat;
        send(0, 15, a);
        drain;
    endtask

    task automatic test_back_to_back;
        int a;
        do_reset;
        mon_en = 1'b1;
        wait_cyc(2);
        expect_frame(3, 10);
        send(3, 10, a);
        total++;
        if (sample_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_full: got %b want 0", sample_ready);
        end
        expect_frame(12, 1);
        expect_repeat;
        send(12, 1, a);
        total += 2;
        if (a != P) begin
            bad++;
            $display("FAIL bp_accept_cycle: got %0d want %0d", a, P);
        end
        if (sample_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_after: got %b want 0", sample_ready);
        end
        drain;
    endtask

    task automatic test_underrun;
        int a;
        do_reset;
        mon_en = 1'b1;
        wait_cyc(4);
        expect_frame(6, 2);
        expect_repeat;
        expect_repeat;
        send(6, 2, a);
        wait_cyc(2 * P);
        total++;
        if (frame_start !== 1'b1 || underrun !== 1'b1) begin
            bad++;
            $display("FAIL underrun_pulse: got fs=%b ur=%b want 1 1", frame_start, underrun);
        end
        wait_cyc(3 * P + 10);
        expect_frame(4, 9);
        send(4, 9, a);
        wait_cyc(4 * P);
        total++;
        if (frame_start !== 1'b1 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL underrun_recover: got fs=%b ur=%b want 1 0", frame_start, underrun);
        end
        wait_cyc(4 * P + 13);
        expect_frame(1, 13);
        send(1, 13, a);
        drain;
    endtask

    task automatic test_boundary_handshake;
        int a;
        do_reset;
        mon_en = 1'b1;
        wait_cyc(P - 1);
        expect_frame(7, 0);
        expect_repeat;
        send(7, 0, a);
        total += 2;
        if (a != P - 1) begin
            bad++;
            $display("FAIL bhs_accept_cycle: got %0d want %0d", a, P - 1);
        end
        if (sample_ready !== 1'b1) begin
            bad++;
            $display("FAIL bhs_pending_empty: got ready=%b want 1", sample_ready);
        end
        wait_cyc(3 * P - 1);
        expect_frame(11, 5);
        send(11, 5, a);
        total++;
        if (a != 3 * P - 1) begin
            bad++;
            $display("FAIL bhs_accept_cycle2: got %0d want %0d", a, 3 * P - 1);
        end
        drain;
    endtask

    task automatic test_sigma_delta;
        int a;
        do_reset;
        mode = 1'b1;
`ifdef PWM_AUDIO_SD_EN
        begin
            int hi0;
            int hi1;
            int stuck;
            logic prev;
            wait_cyc(2);
            send(8, 0, a);
            wait_cyc(2 * P + 3);
            hi0   = 0;
            hi1   = 0;
            stuck = 0;
            prev  = pwm[0];
            repeat (32) begin
                @(negedge clk);
                hi0 += int'(pwm[0]);
                hi1 += int'(pwm[1]);
                if (pwm[0] === prev) stuck++;
                prev = pwm[0];
            end
            total += 3;
            if (hi0 != 16) begin
                bad++;
                $display("FAIL sd_density_ch0: got %0d want 16 of 32", hi0);
            end
            if (stuck != 0) begin
                bad++;
                $display("FAIL sd_alternate_ch0: got %0d repeats want 0", stuck);
            end
            if (hi1 != 0) begin
                bad++;
                $display("FAIL sd_density_ch1: got %0d want 0", hi1);
            end
        end
`else
        mon_en = 1'b1;
        wait_cyc(2);
        expect_frame(8, 0);
        expect_repeat;
        expect_repeat;
        send(8, 0, a);
        drain;
`endif
        mode = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        mode         = 1'b0;
        test_reset;
        test_duty;
        test_back_to_back;
        test_underrun;
        test_boundary_handshake;
        test_sigma_delta;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
